// File: rtl/cpu_mc_if.sv
// Valid/ready instruction and data buses between the cpu_mc core and its memory system.
interface cpu_mc_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_wstrb;
    logic [31:0]       dmem_wdata;
    logic              dmem_ready;
    logic [31:0]       dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output imem_ready, imem_rdata, dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/cpu_mc.sv
// Multi-cycle RV32I core: FETCH -> EXEC -> [MEM] -> WB with valid/ready buses, one instruction
// in flight, and a sticky HALT state for illegal or misaligned operations.
module cpu_mc #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned ADDR_W       = 32,
    parameter bit          HALT_ON_ERR  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    cpu_mc_if.master    bus,
    output logic        retire,
    output logic [31:0] pc_o,
    output logic        halted
);
    typedef enum logic [2:0] {StFetch, StExec, StMem, StWb, StHalt} state_e;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    state_e      state_q, state_d;
    logic [31:0] pc_q, ir_q, next_pc_q, ea_q, wb_val_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        wb_en_q, we_q;
    logic [31:0] rf_q [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1_idx, rs2_idx;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4, op_b, alu_res;
    logic        br_taken;

    assign opcode  = ir_q[6:0];
    assign rd      = ir_q[11:7];
    assign f3      = ir_q[14:12];
    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];
    assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u   = {ir_q[31:12], 12'b0};
    assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 : rf_q[rs1_idx];
    assign rs2_val = (rs2_idx == 5'd0) ? 32'd0 : rf_q[rs2_idx];
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        op_b = (opcode == OpReg) ? rs2_val : imm_i;
        case (f3)
            3'd0:    alu_res = (opcode == OpReg && ir_q[30]) ? rs1_val - op_b : rs1_val + op_b;
            3'd1:    alu_res = rs1_val << op_b[4:0];
            3'd2:    alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
            3'd3:    alu_res = {31'd0, rs1_val < op_b};
            3'd4:    alu_res = rs1_val ^ op_b;
            3'd5:    alu_res = ir_q[30] ? 32'($signed(rs1_val) >>> op_b[4:0])
                                        : rs1_val >> op_b[4:0];
            3'd6:    alu_res = rs1_val | op_b;
            default: alu_res = rs1_val & op_b;
        endcase
        case (f3)
            3'd0:    br_taken = (rs1_val == rs2_val);
            3'd1:    br_taken = (rs1_val != rs2_val);
            3'd4:    br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'd5:    br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6:    br_taken = (rs1_val < rs2_val);
            3'd7:    br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    logic        illegal, is_load, is_store, jump, wb_en;
    logic [31:0] target, ea, wb_val, next_pc, wdata;
    logic [3:0]  wstrb;

    always_comb begin
        illegal  = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        jump     = 1'b0;
        wb_en    = (rd != 5'd0);
        wb_val   = alu_res;
        target   = pc_q + imm_b;
        ea       = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
        case (opcode)
            OpLui:    wb_val = imm_u;
            OpAuipc:  wb_val = pc_q + imm_u;
            OpJal: begin
                wb_val = pc_plus4;
                jump   = 1'b1;
                target = pc_q + imm_j;
            end
            OpJalr: begin
                wb_val  = pc_plus4;
                jump    = 1'b1;
                target  = (rs1_val + imm_i) & ~32'd1;
                illegal = (f3 != 3'd0);
            end
            OpBranch: begin
                wb_en   = 1'b0;
                jump    = br_taken;
                illegal = (f3[2:1] == 2'b01);
            end
            OpLoad: begin
                is_load = 1'b1;
                illegal = (f3 == 3'd3) || (f3[2:1] == 2'b11);
            end
            OpStore: begin
                wb_en    = 1'b0;
                is_store = 1'b1;
                illegal  = (f3[2] || f3[1:0] == 2'b11);
            end
            OpImm, OpReg: ;
            default:  illegal = 1'b1;
        endcase
        // Alignment: halfwords need ea[0]=0, words need ea[1:0]=0.
        if ((is_load || is_store) &&
            ((f3[1:0] == 2'b01 && ea[0]) || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00))) begin
            illegal = 1'b1;
        end
        if (jump && target[1:0] != 2'b00) begin
            illegal = 1'b1;
        end
        next_pc = (jump && !illegal) ? target : pc_plus4;
        case (f3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << ea[1:0];
                wdata = {4{rs2_val[7:0]}};
            end
            2'b01: begin
                wstrb = ea[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rs2_val[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = rs2_val;
            end
        endcase
    end

    logic [31:0] ld_shift, load_val;
    assign ld_shift = bus.dmem_rdata >> {ea_q[1:0], 3'b000};

    always_comb begin
        case (f3)
            3'd0:    load_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1:    load_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd4:    load_val = {24'd0, ld_shift[7:0]};
            3'd5:    load_val = {16'd0, ld_shift[15:0]};
            default: load_val = ld_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: if (bus.imem_ready) state_d = StExec;
            StExec: begin
                if (illegal && HALT_ON_ERR)             state_d = StHalt;
                else if (!illegal && (is_load || is_store)) state_d = StMem;
                else                                    state_d = StWb;
            end
            StMem:   if (bus.dmem_ready) state_d = StWb;
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StFetch;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_VECTOR;
            ir_q      <= '0;
            next_pc_q <= '0;
            ea_q      <= '0;
            wb_val_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wb_en_q   <= 1'b0;
            we_q      <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                StFetch: if (bus.imem_ready) ir_q <= bus.imem_rdata;
                StExec: begin
                    next_pc_q <= next_pc;
                    ea_q      <= ea;
                    wb_val_q  <= wb_val;
                    wb_en_q   <= wb_en && !illegal;
                    we_q      <= is_store;
                    wstrb_q   <= is_store ? wstrb : 4'b0000;
                    wdata_q   <= wdata;
                end
                StMem: if (bus.dmem_ready && !we_q) wb_val_q <= load_val;
                StWb: begin
                    pc_q <= next_pc_q;
                    if (wb_en_q) rf_q[rd] <= wb_val_q;
                end
                default: ;
            endcase
        end
    end

    // Requests are gated by reset so an abandoned transfer drops the instant reset asserts.
    assign bus.imem_req   = reset && (state_q == StFetch);
    assign bus.imem_addr  = pc_q[ADDR_W-1:0];
    assign bus.dmem_req   = reset && (state_q == StMem);
    assign bus.dmem_we    = bus.dmem_req && we_q;
    assign bus.dmem_addr  = {ea_q[ADDR_W-1:2], 2'b00};
    assign bus.dmem_wstrb = bus.dmem_req ? wstrb_q : 4'b0000;
    assign bus.dmem_wdata = wdata_q;
    assign retire         = (state_q == StWb);
    assign halted         = (state_q == StHalt);
    assign pc_o           = pc_q;
endmodule
